// File: rtl/mem_responder.sv
// mem_responder: byte-wide RAM/IO responder for the CPU external memory bus.
// Provides a synchronous byte RAM, a TX FIFO with io_buffer_full back-pressure,
// a single-byte RX holding register, and a sim_halt strobe.
// Optional feature macro: MEM_RESP_RX_EN (RX holding register and capture logic).
module mem_responder #(
  parameter int RAM_ADDR_W = 17,
  parameter int TX_DEPTH   = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        rdy_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_dout,
  output logic [7:0]  mem_din,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_halt
);

  localparam int PTR_W = $clog2(TX_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] FULL_COUNT = PTR_W'(TX_DEPTH);

  typedef enum logic [1:0] {
    SEL_RAM,
    SEL_DATA,
    SEL_STATUS,
    SEL_NONE
  } sel_e;

  sel_e                  sel;
  logic                  rd_cyc;
  logic                  wr_cyc;
  logic [RAM_ADDR_W-1:0] ram_idx;
  logic [7:0]            ram [0:(1 << RAM_ADDR_W) - 1];

  logic [7:0]            fifo [0:TX_DEPTH-1];
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [PTR_W-1:0]      count;
  logic                  tx_pop;
  logic                  tx_push;

  logic                  rx_full;
  logic [7:0]            rx_byte;

  logic                  unused_addr;
  assign unused_addr = ^mem_a[31:18];

  assign rd_cyc  = rdy_in && !mem_wr;
  assign wr_cyc  = rdy_in && mem_wr;
  assign ram_idx = mem_a[RAM_ADDR_W-1:0];

  // Address decode: IO window is mem_a[17:16] == 2'b11, everything else is RAM.
  always_comb begin
    sel = SEL_RAM;
    if (mem_a[17:16] == 2'b11) begin
      if (mem_a[15:0] == 16'h0000)      sel = SEL_DATA;
      else if (mem_a[15:0] == 16'h0004) sel = SEL_STATUS;
      else                              sel = SEL_NONE;
    end
  end

  // TX FIFO occupancy; pointers carry one extra bit so full and empty differ.
  assign count          = wptr - rptr;
  assign io_buffer_full = (count == FULL_COUNT);
  assign tx_valid       = (count != '0);
  assign tx_data        = fifo[rptr[IDX_W-1:0]];
  assign tx_pop         = tx_valid && tx_ready;
  // A push while full is accepted only if the head leaves in the same cycle.
  assign tx_push        = wr_cyc && (sel == SEL_DATA) && (!io_buffer_full || tx_pop);

  // RAM write port; contents are intentionally not reset.
  always_ff @(posedge clk_in) begin
    if (wr_cyc && (sel == SEL_RAM)) ram[ram_idx] <= mem_dout;
  end

  // FIFO storage write; the array is not reset (tx_data is don't-care when empty).
  always_ff @(posedge clk_in) begin
    if (tx_push) fifo[wptr[IDX_W-1:0]] <= mem_dout;
  end

  // FIFO pointer update.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (tx_push) wptr <= wptr + 1'b1;
      if (tx_pop)  rptr <= rptr + 1'b1;
    end
  end

`ifdef MEM_RESP_RX_EN
  logic rx_cap;
  logic rx_pop;

  assign rx_cap   = rx_valid && !rx_full;
  assign rx_pop   = rd_cyc && (sel == SEL_DATA) && rx_full;
  assign rx_ready = !rx_full;

  // RX holding register: capture only when empty, CPU read of 0x30000 empties it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rx_full <= 1'b0;
      rx_byte <= '0;
    end else if (rx_cap) begin
      rx_full <= 1'b1;
      rx_byte <= rx_data;
    end else if (rx_pop) begin
      rx_full <= 1'b0;
    end
  end
`else
  logic unused_rx;
  assign unused_rx = ^{rx_valid, rx_data};
  assign rx_full   = 1'b0;
  assign rx_byte   = '0;
  assign rx_ready  = 1'b0;
`endif

  // Registered read data: one-cycle latency, held when idle-writing or rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      mem_din <= '0;
    end else if (rd_cyc) begin
      case (sel)
        SEL_RAM:    mem_din <= ram[ram_idx];
        SEL_DATA:   mem_din <= rx_full ? rx_byte : 8'h00;
        SEL_STATUS: mem_din <= {6'b0, rx_full, io_buffer_full};
        default:    mem_din <= 8'h00;
      endcase
    end
  end

  // Simulation halt strobe on a write to 0x30004.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) sim_halt <= 1'b0;
    else           sim_halt <= wr_cyc && (sel == SEL_STATUS);
  end

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios plus randomized RAM and TX
// traffic checked against array/queue reference models.
module tb_mem_responder;

  logic        clk_in;
  logic        rst_n_in;
  logic        rdy_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        io_buffer_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sim_halt;

  int checks = 0;
  int errors = 0;

`ifdef MEM_RESP_RX_EN
  localparam bit RX_ON = 1'b1;
`else
  localparam bit RX_ON = 1'b0;
`endif

  mem_responder #(.RAM_ADDR_W(17), .TX_DEPTH(8)) dut (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .rdy_in         (rdy_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_dout       (mem_dout),
    .mem_din        (mem_din),
    .io_buffer_full (io_buffer_full),
    .tx_valid       (tx_valid),
    .tx_data        (tx_data),
    .tx_ready       (tx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .rx_ready       (rx_ready),
    .sim_halt       (sim_halt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #1_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_rd(input logic [31:0] a);
    mem_a = a; mem_wr = 1'b0; mem_dout = 8'h00;
  endtask

  task automatic set_wr(input logic [31:0] a, input logic [7:0] d);
    mem_a = a; mem_wr = 1'b1; mem_dout = d;
  endtask

  task automatic set_idle();
    set_rd(32'h0);
  endtask

  task automatic test_reset();
    rst_n_in = 1'b1; rdy_in = 1'b1; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    set_idle();
    #2 rst_n_in = 1'b0;
    step(); step();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL reset_mem_din got %h exp 00", mem_din); end
    checks++; if (io_buffer_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", io_buffer_full); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got %b exp 0", tx_valid); end
    checks++; if (rx_ready !== RX_ON) begin errors++; $display("FAIL reset_rx_ready got %b exp %b", rx_ready, RX_ON); end
    checks++; if (sim_halt !== 1'b0) begin errors++; $display("FAIL reset_sim_halt got %b exp 0", sim_halt); end
    rst_n_in = 1'b1;
    step();
  endtask

  task automatic test_ram_basic();
    set_wr(32'h0000_0010, 8'hA5); step();
    set_rd(32'h0000_0010); step();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_read got %h exp a5", mem_din); end
    set_rd(32'h0003_0008); step();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL io_other_read got %h exp 00", mem_din); end
    set_rd(32'h0002_0010); step();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL ram_alias got %h exp a5", mem_din); end
    set_idle();
  endtask

  task automatic test_burst();
    logic [7:0] vals [4];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      set_wr(32'h100 + i, vals[i]); step();
    end
    for (int i = 0; i < 4; i++) begin
      set_rd(32'h100 + i); step();
      checks++; if (mem_din !== vals[i]) begin errors++; $display("FAIL burst_read[%0d] got %h exp %h", i, mem_din, vals[i]); end
    end
    set_idle(); step();
  endtask

  task automatic test_random_ram();
    logic [7:0] mdl [64];
    bit         vld [64];
    for (int i = 0; i < 64; i++) vld[i] = 1'b0;
    for (int n = 0; n < 200; n++) begin
      int unsigned k;
      logic [31:0] a;
      k = $urandom_range(0, 63);
      a = 32'h200 + k + (($urandom_range(0, 1) != 0) ? 32'h2_0000 : 32'h0);
      if (!vld[k] || $urandom_range(0, 1) == 0) begin
        logic [7:0] d;
        d = 8'($urandom);
        set_wr(a, d); step();
        mdl[k] = d; vld[k] = 1'b1;
      end else begin
        set_rd(a); step();
        checks++; if (mem_din !== mdl[k]) begin errors++; $display("FAIL rand_ram addr %h got %h exp %h", a, mem_din, mdl[k]); end
      end
    end
    set_idle(); step();
  endtask

  task automatic test_tx_fifo();
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      set_wr(32'h0003_0000, 8'(i)); step();
      checks++; if (io_buffer_full !== (i >= 8)) begin errors++; $display("FAIL tx_fill_full[%0d] got %b exp %b", i, io_buffer_full, (i >= 8)); end
    end
    set_idle();
    tx_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== 8'(i)) begin errors++; $display("FAIL tx_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, 8'(i)); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL tx_ninth_absent got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_full_push_pop();
    logic [7:0] q [$];
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_wr(32'h0003_0000, 8'hA0 + 8'(i)); step();
      q.push_back(8'hA0 + 8'(i));
    end
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL fpp_full_before got %b exp 1", io_buffer_full); end
    tx_ready = 1'b1;
    set_wr(32'h0003_0000, 8'h55); step();
    void'(q.pop_front()); q.push_back(8'h55);
    tx_ready = 1'b0; set_idle();
    checks++; if (io_buffer_full !== 1'b1) begin errors++; $display("FAIL fpp_full_after got %b exp 1", io_buffer_full); end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== q[i]) begin errors++; $display("FAIL fpp_drain[%0d] got v=%b d=%h exp v=1 d=%h", i, tx_valid, tx_data, q[i]); end
      step();
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL fpp_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_random_tx();
    logic [7:0] q [$];
    for (int n = 0; n < 300; n++) begin
      bit wr, tr, pop, push;
      logic [7:0] d;
      checks++;
      if (tx_valid !== (q.size() != 0) || io_buffer_full !== (q.size() == 8) ||
          (q.size() != 0 && tx_data !== q[0])) begin
        errors++;
        $display("FAIL rand_tx[%0d] got v=%b f=%b d=%h exp v=%b f=%b d=%h", n, tx_valid, io_buffer_full, tx_data,
                 (q.size() != 0), (q.size() == 8), (q.size() != 0) ? q[0] : tx_data);
      end
      wr = ($urandom_range(0, 2) != 0); tr = ($urandom_range(0, 2) == 0); d = 8'($urandom);
      tx_ready = tr;
      if (wr) set_wr(32'h0003_0000, d); else set_idle();
      step();
      pop  = tr && (q.size() != 0);
      push = wr && (q.size() < 8 || pop);
      if (pop)  void'(q.pop_front());
      if (push) q.push_back(d);
    end
    set_idle(); tx_ready = 1'b1;
    for (int n = 0; n < 12 && q.size() != 0; n++) begin
      checks++; if (tx_valid !== 1'b1 || tx_data !== q[0]) begin errors++; $display("FAIL rand_tx_drain got v=%b d=%h exp v=1 d=%h", tx_valid, tx_data, q[0]); end
      step(); void'(q.pop_front());
    end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rand_tx_empty got %b exp 0", tx_valid); end
    tx_ready = 1'b0;
  endtask

  task automatic test_rx();
    set_idle();
    rx_valid = 1'b1; rx_data = 8'h3C; step();
    rx_data = 8'h77; step();
    rx_valid = 1'b0;
    checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL rx_ready_full got %b exp 0", rx_ready); end
    set_rd(32'h0003_0004); step();
    checks++; if (mem_din !== (RX_ON ? 8'h02 : 8'h00)) begin errors++; $display("FAIL rx_status got %h exp %h", mem_din, (RX_ON ? 8'h02 : 8'h00)); end
    rdy_in = 1'b0; set_rd(32'h0003_0000); step();
    checks++; if (mem_din !== (RX_ON ? 8'h02 : 8'h00)) begin errors++; $display("FAIL rx_hold_rdy_low got %h exp %h", mem_din, (RX_ON ? 8'h02 : 8'h00)); end
    rdy_in = 1'b1; set_rd(32'h0003_0000); step();
    checks++; if (mem_din !== (RX_ON ? 8'h3C : 8'h00)) begin errors++; $display("FAIL rx_pop_data got %h exp %h", mem_din, (RX_ON ? 8'h3C : 8'h00)); end
    checks++; if (rx_ready !== RX_ON) begin errors++; $display("FAIL rx_ready_after_pop got %b exp %b", rx_ready, RX_ON); end
    set_rd(32'h0003_0000); step();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rx_pop_empty got %h exp 00", mem_din); end
    set_idle();
  endtask

  task automatic test_reset_mid();
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_wr(32'h0003_0000, 8'(i + 1)); step();
    end
    set_rd(32'h0003_0004); step();
    checks++; if (mem_din !== 8'h01) begin errors++; $display("FAIL rst_pre_status got %h exp 01", mem_din); end
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %b exp 1", tx_valid); end
    #2 rst_n_in = 1'b0;
    #1;
    checks++; if (tx_valid !== 1'b0 || io_buffer_full !== 1'b0) begin errors++; $display("FAIL rst_async_fifo got v=%b f=%b exp v=0 f=0", tx_valid, io_buffer_full); end
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_async_din got %h exp 00", mem_din); end
    step(); step();
    rst_n_in = 1'b1;
    set_rd(32'h0003_0004); step();
    checks++; if (mem_din !== 8'h00) begin errors++; $display("FAIL rst_post_status got %h exp 00", mem_din); end
    set_idle();
  endtask

  task automatic test_sim_halt();
    set_wr(32'h0003_0004, 8'h00); step();
    checks++; if (sim_halt !== 1'b1) begin errors++; $display("FAIL halt_pulse got %b exp 1", sim_halt); end
    set_idle(); step();
    checks++; if (sim_halt !== 1'b0) begin errors++; $display("FAIL halt_one_cycle got %b exp 0", sim_halt); end
    set_rd(32'h0000_0010); step();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL rdy_pre_read got %h exp a5", mem_din); end
    rdy_in = 1'b0;
    set_wr(32'h0003_0004, 8'h00); step();
    checks++; if (sim_halt !== 1'b0) begin errors++; $display("FAIL halt_rdy_low got %b exp 0", sim_halt); end
    set_wr(32'h0003_0000, 8'h99); step();
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL push_rdy_low got %b exp 0", tx_valid); end
    set_wr(32'h0000_0010, 8'hFF); step();
    set_rd(32'h0000_0100); step();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL din_hold_rdy_low got %h exp a5", mem_din); end
    rdy_in = 1'b1;
    set_rd(32'h0000_0010); step();
    checks++; if (mem_din !== 8'hA5) begin errors++; $display("FAIL write_rdy_low got %h exp a5", mem_din); end
    set_idle();
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_burst();
    test_random_ram();
    test_tx_fifo();
    test_full_push_pop();
    test_random_tx();
    test_rx();
    test_reset_mid();
    test_sim_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
